// File: rtl/operand_accumulator_pkg.sv
// Shared types and defaults for the operand accumulator and its adder.
// State encodings are fixed so that waveforms and any external decoders agree.
package operand_accumulator_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } acc_state_e;

  localparam int DEF_NO_BITS  = 8;
  localparam int DEF_NO_OPS   = 4;
  localparam int DEF_ACC_BITS = 10;

  function automatic int count_width(input int no_ops);
    return $clog2(no_ops) + 1;
  endfunction

endpackage

// File: rtl/operand_accumulator_if.sv
// Operand-in / result-out handshake bundle for the operand accumulator.
// The master side is the producer of operands and the consumer of the result.
interface operand_accumulator_if #(
  parameter int NO_BITS  = 8,
  parameter int ACC_BITS = 10
);
  logic                start;
  logic                in_valid;
  logic                in_ready;
  logic [NO_BITS-1:0]  in_data;
  logic                out_valid;
  logic                out_ready;
  logic [ACC_BITS-1:0] sum;
  logic                overflow;
  logic                busy;

  modport master (
    output start, in_valid, in_data, out_ready,
    input  in_ready, out_valid, sum, overflow, busy
  );

  modport slave (
    input  start, in_valid, in_data, out_ready,
    output in_ready, out_valid, sum, overflow, busy
  );
endinterface

// File: rtl/operand_accumulator_adder.sv
// Parameterised ripple-carry adder; out carries the carry-out in its top bit.
module Adder #(
  parameter int NO_BITS = 8
) (
  input  logic [NO_BITS-1:0] a,
  input  logic [NO_BITS-1:0] b,
  input  logic               cin,
  output logic [NO_BITS:0]   out
);

  logic [NO_BITS-1:0] sum_bits;
  logic               carry;

  // Carry is a scalar walked bit by bit so the chain stays a true ripple.
  always_comb begin
    sum_bits = '0;
    carry    = cin;
    for (int i = 0; i < NO_BITS; i++) begin
      sum_bits[i] = a[i] ^ b[i] ^ carry;
      carry       = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
  end

  assign out = {carry, sum_bits};

endmodule

// File: rtl/operand_accumulator.sv
// Accumulates NO_OPS operands through one ripple-carry Adder and hands the
// total (with a sticky overflow flag) downstream over a valid/ready handshake.
module operand_accumulator
  import operand_accumulator_pkg::*;
#(
  parameter int NO_BITS  = DEF_NO_BITS,
  parameter int NO_OPS   = DEF_NO_OPS,
  parameter int ACC_BITS = DEF_ACC_BITS
) (
  input logic                 clk,
  input logic                 rst,
  operand_accumulator_if.slave bus
);

  localparam int CNT_W = count_width(NO_OPS);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NO_OPS - 1);

  acc_state_e          state_q, state_d;
  logic [ACC_BITS-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                ovf_q, ovf_d;

  logic [ACC_BITS-1:0] operand_ext;
  logic [ACC_BITS:0]   adder_out;
  logic                transfer;

  assign operand_ext = ACC_BITS'(bus.in_data);

  Adder #(.NO_BITS(ACC_BITS)) u_adder (
    .a   (acc_q),
    .b   (operand_ext),
    .cin (1'b0),
    .out (adder_out)
  );

  assign transfer = (state_q == ACCUM) && bus.in_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // The result is left in acc_q after DONE and only cleared by the next start.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          acc_d   = '0;
          count_d = '0;
          ovf_d   = 1'b0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (transfer) begin
          acc_d   = adder_out[ACC_BITS-1:0];
          ovf_d   = ovf_q | adder_out[ACC_BITS];
          count_d = count_q + 1'b1;
          if (count_q == LAST_IDX) state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == ACCUM);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q == ACCUM) || (state_q == DONE);
  assign bus.sum       = acc_q;
  assign bus.overflow  = ovf_q;

endmodule
